// File: rtl/sm3_expnd_pkg.sv
// Shared types, sizes and bit-level helpers for the SM3 message-expansion engine.
package sm3_expnd_pkg;

    localparam int WORD_W    = 32;
    localparam int BLK_WORDS = 16;
    localparam int ROUNDS    = 64;

    typedef logic [WORD_W-1:0]     word_t;
    typedef word_t [BLK_WORDS-1:0] blk_t;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_EXPND = 1'b1
    } exp_state_t;

    function automatic word_t rotl32(input word_t x, input int unsigned n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

    function automatic word_t p1(input word_t x);
        return x ^ rotl32(x, 15) ^ rotl32(x, 23);
    endfunction

endpackage

// File: rtl/sm3_expnd_lane_calc.sv
// Combinational SM3 expansion of LANES new words from the 16-word window W[j..j+15].
module sm3_expnd_lane_calc
    import sm3_expnd_pkg::*;
#(
    parameter int LANES = 2
) (
    input  blk_t                win,
    output word_t [LANES-1:0]   new_w
);

    // Window extended by the new words so later lanes can chain on earlier ones.
    word_t ext [BLK_WORDS+LANES];

    always_comb begin
        for (int k = 0; k < BLK_WORDS; k++) begin
            ext[k] = win[k];
        end
        for (int i = 0; i < LANES; i++) begin
            ext[BLK_WORDS+i] = p1(ext[i] ^ ext[i+7] ^ rotl32(ext[i+13], 15))
                             ^ rotl32(ext[i+3], 7) ^ ext[i+10];
        end
        for (int i = 0; i < LANES; i++) begin
            new_w[i] = ext[BLK_WORDS+i];
        end
    end

endmodule

// File: rtl/sm3_expnd_mlane_core.sv
// SM3 message expander: loads 512-bit blocks over a DATA_W bus, streams LANES (Wj, W'j) pairs per beat.
module sm3_expnd_mlane_core
    import sm3_expnd_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int LANES   = 2,
    parameter int DBL_BUF = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       pad_inpt_d_i,
    input  logic                    pad_inpt_vld_i,
    input  logic                    pad_inpt_lst_i,
    output logic                    pad_inpt_rdy_o,
    input  logic                    expnd_otpt_ena_i,
    output logic [WORD_W*LANES-1:0] expnd_otpt_wj_o,
    output logic [WORD_W*LANES-1:0] expnd_otpt_wjj_o,
    output logic                    expnd_otpt_lst_o,
    output logic                    expnd_otpt_vld_o
);

    localparam int LD_BEATS  = 512 / DATA_W;
    localparam int WPB       = DATA_W / WORD_W;
    localparam int OUT_BEATS = ROUNDS / LANES;
    localparam int LDC_W     = $clog2(LD_BEATS);
    localparam int OBC_W     = $clog2(OUT_BEATS);

    exp_state_t       state_q, state_d;
    logic [LDC_W-1:0] ld_cnt_q, ld_cnt_d;
    logic [OBC_W-1:0] beat_cnt_q, beat_cnt_d;
    blk_t             win_q, win_d;
    blk_t             buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic             buf_lst_q, buf_lst_d;
    logic             blk_lst_q, blk_lst_d;
    logic             lst_q, lst_d;

    word_t [LANES-1:0] new_w;
    blk_t              fill, shifted;
    logic [3:0]        widx;
    logic              accept, ld_last, xfer, out_last, fetch;

    sm3_expnd_lane_calc #(.LANES(LANES)) u_lane_calc (
        .win   (win_q),
        .new_w (new_w)
    );

    assign pad_inpt_rdy_o   = (DBL_BUF != 0) ? !buf_full_q : (state_q == ST_LOAD);
    assign expnd_otpt_vld_o = (state_q == ST_EXPND);
    assign expnd_otpt_lst_o = lst_q;

    assign accept   = pad_inpt_vld_i && pad_inpt_rdy_o;
    assign ld_last  = (ld_cnt_q == LDC_W'(LD_BEATS - 1));
    assign xfer     = expnd_otpt_vld_o && expnd_otpt_ena_i;
    assign out_last = (beat_cnt_q == OBC_W'(OUT_BEATS - 1));
    // The expander may reload from the buffer in the same edge as its final transfer.
    assign fetch    = (DBL_BUF != 0) && buf_full_q && ((state_q == ST_LOAD) || (xfer && out_last));

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves a latch.
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        beat_cnt_d = beat_cnt_q;
        win_d      = win_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        buf_lst_d  = buf_lst_q;
        blk_lst_d  = blk_lst_q;
        lst_d      = lst_q;
        widx       = '0;

        fill = (DBL_BUF != 0) ? buf_q : win_q;
        for (int m = 0; m < WPB; m++) begin
            widx       = 4'(int'(ld_cnt_q) * WPB + m);
            fill[widx] = pad_inpt_d_i[DATA_W-1-WORD_W*m -: WORD_W];
        end

        shifted = win_q;
        for (int k = 0; k < BLK_WORDS - LANES; k++) begin
            shifted[k] = win_q[k+LANES];
        end
        for (int i = 0; i < LANES; i++) begin
            shifted[BLK_WORDS-LANES+i] = new_w[i];
        end

        if (accept) begin
            ld_cnt_d = ld_last ? '0 : ld_cnt_q + LDC_W'(1);
            if (DBL_BUF != 0) begin
                buf_d = fill;
                if (ld_last) begin
                    buf_full_d = 1'b1;
                    buf_lst_d  = pad_inpt_lst_i;
                end
            end else begin
                win_d = fill;
                if (ld_last) begin
                    state_d    = ST_EXPND;
                    beat_cnt_d = '0;
                    blk_lst_d  = pad_inpt_lst_i;
                    lst_d      = 1'b0;
                end
            end
        end

        if (xfer) begin
            if (out_last) begin
                state_d    = ST_LOAD;
                beat_cnt_d = '0;
                lst_d      = 1'b0;
            end else begin
                win_d      = shifted;
                beat_cnt_d = beat_cnt_q + OBC_W'(1);
                lst_d      = blk_lst_q && (beat_cnt_q == OBC_W'(OUT_BEATS - 2));
            end
        end

        if (fetch) begin
            win_d      = buf_q;
            buf_full_d = 1'b0;
            state_d    = ST_EXPND;
            beat_cnt_d = '0;
            blk_lst_d  = buf_lst_q;
            lst_d      = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD;
            ld_cnt_q   <= '0;
            beat_cnt_q <= '0;
            win_q      <= '0;
            buf_full_q <= 1'b0;
            buf_lst_q  <= 1'b0;
            blk_lst_q  <= 1'b0;
            lst_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            win_q      <= win_d;
            buf_full_q <= buf_full_d;
            buf_lst_q  <= buf_lst_d;
            blk_lst_q  <= blk_lst_d;
            lst_q      <= lst_d;
        end
    end

    // NOTE: buffer contents need no reset; buf_full_q alone says whether they are meaningful.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    always_comb begin
        expnd_otpt_wj_o  = '0;
        expnd_otpt_wjj_o = '0;
        for (int k = 0; k < LANES; k++) begin
            expnd_otpt_wj_o[WORD_W*(LANES-k)-1 -: WORD_W]  = win_q[k];
            expnd_otpt_wjj_o[WORD_W*(LANES-k)-1 -: WORD_W] = win_q[k] ^ win_q[k+4];
        end
    end

endmodule

// File: tb/tb_sm3_expnd_mlane_core.sv
// Directed bench for sm3_expnd_mlane_core: default config plus a DATA_W x LANES x DBL_BUF sweep.
module tb_sm3_expnd_mlane_core;
    import sm3_expnd_pkg::*;

    localparam int NCFG = 9;

    // Config 0 is the default (64, 2, 1); configs 1..8 sweep {32,128} x {1,4} x {0,1}.
    function automatic int cfg_dw(input int i);
        if (i == 0) return 64;
        return (((i - 1) & 4) != 0) ? 128 : 32;
    endfunction
    function automatic int cfg_l(input int i);
        if (i == 0) return 2;
        return (((i - 1) & 2) != 0) ? 4 : 1;
    endfunction
    function automatic int cfg_db(input int i);
        if (i == 0) return 1;
        return (i - 1) & 1;
    endfunction

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [127:0] sw_d   [NCFG];
    logic         sw_vld [NCFG];
    logic         sw_lst [NCFG];
    logic         sw_ena [NCFG];
    wire          sw_rdy [NCFG];
    wire  [127:0] sw_wj  [NCFG];
    wire  [127:0] sw_wjj [NCFG];
    wire          sw_lo  [NCFG];
    wire          sw_vo  [NCFG];

    int checks   = 0;
    int failures = 0;

    word_t msg     [2][16];
    word_t exp_w   [2][68];
    logic  exp_lst [2];
    word_t obs_w   [128];

    initial forever #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int DW = cfg_dw(g);
        localparam int L  = cfg_l(g);
        localparam int DB = cfg_db(g);
        logic [32*L-1:0] wj, wjj;
        logic            rdy, lo, vo;

        sm3_expnd_mlane_core #(.DATA_W(DW), .LANES(L), .DBL_BUF(DB)) u_dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .pad_inpt_d_i     (sw_d[g][DW-1:0]),
            .pad_inpt_vld_i   (sw_vld[g]),
            .pad_inpt_lst_i   (sw_lst[g]),
            .pad_inpt_rdy_o   (rdy),
            .expnd_otpt_ena_i (sw_ena[g]),
            .expnd_otpt_wj_o  (wj),
            .expnd_otpt_wjj_o (wjj),
            .expnd_otpt_lst_o (lo),
            .expnd_otpt_vld_o (vo)
        );

        assign sw_rdy[g] = rdy;
        assign sw_wj[g]  = 128'(wj);
        assign sw_wjj[g] = 128'(wjj);
        assign sw_lo[g]  = lo;
        assign sw_vo[g]  = vo;
    end

    function automatic word_t rl(input word_t x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    task automatic gen_model(input int bi);
        word_t x;
        for (int j = 0; j < 16; j++) exp_w[bi][j] = msg[bi][j];
        for (int j = 16; j < 68; j++) begin
            x = exp_w[bi][j-16] ^ exp_w[bi][j-9] ^ rl(exp_w[bi][j-3], 15);
            exp_w[bi][j] = x ^ rl(x, 15) ^ rl(x, 23) ^ rl(exp_w[bi][j-13], 7) ^ exp_w[bi][j-6];
        end
    endtask

    task automatic fill_msg(input int bi, input int seed);
        for (int j = 0; j < 16; j++)
            msg[bi][j] = (32'h9e3779b9 * word_t'(j + seed)) ^ (32'h7f4a7c15 >> j);
    endtask

    // Presents one block; lst_i is inverted on non-final beats since it must be ignored there.
    task automatic send_block(input int idx, input int bi, input logic lst);
        int dw    = cfg_dw(idx);
        int wpb   = dw / 32;
        int nb    = 512 / dw;
        int b     = 0;
        int guard = 0;
        logic [127:0] beat;
        while (b < nb && guard < 2000) begin
            @(negedge clk);
            guard++;
            beat = '0;
            for (int m = 0; m < wpb; m++) beat[dw-1-32*m -: 32] = msg[bi][b*wpb+m];
            sw_d[idx]   = beat;
            sw_vld[idx] = 1'b1;
            sw_lst[idx] = (b == nb - 1) ? lst : !lst;
            if (sw_rdy[idx] === 1'b1) b++;
        end
        @(negedge clk);
        sw_vld[idx] = 1'b0;
        sw_lst[idx] = 1'b0;
        checks++;
        if (b != nb || sw_rdy[idx] !== 1'b0) begin
            failures++;
            $display("FAIL load_done cfg=%0d beats=%0d need=%0d rdy=%b want rdy=0", idx, b, nb, sw_rdy[idx]);
        end
    endtask

    // Consumes nblk blocks with ena drawn at duty percent, comparing every transferred beat.
    task automatic collect(input int idx, input int nblk, input int duty, input bit chk_gap);
        int L     = cfg_l(idx);
        int nbo   = 64 / L;
        int got   = 0;
        int guard = 0;
        int gaps  = 0;
        int b, bi;
        bit started = 0;
        bit held    = 0;
        logic [127:0] hwj, hwjj, ewj, ewjj;
        logic elst;
        while (got < nblk * nbo) begin
            @(negedge clk);
            guard++;
            if (guard > 4000) begin
                checks++;
                failures++;
                $display("FAIL collect_timeout cfg=%0d got=%0d need=%0d", idx, got, nblk * nbo);
                break;
            end
            if (held) begin
                checks++;
                if (sw_vo[idx] !== 1'b1 || sw_wj[idx] !== hwj || sw_wjj[idx] !== hwjj) begin
                    failures++;
                    $display("FAIL stall_hold cfg=%0d beat=%0d vld=%b wj=%h want %h", idx, got, sw_vo[idx], sw_wj[idx], hwj);
                end
            end
            held = 0;
            sw_ena[idx] = ($urandom_range(0, 99) < duty);
            if (sw_vo[idx] === 1'b1) begin
                started = 1;
                if (sw_ena[idx]) begin
                    bi   = got / nbo;
                    b    = got % nbo;
                    ewj  = '0;
                    ewjj = '0;
                    for (int k = 0; k < L; k++) begin
                        ewj[32*(L-k)-1 -: 32]  = exp_w[bi][b*L+k];
                        ewjj[32*(L-k)-1 -: 32] = exp_w[bi][b*L+k] ^ exp_w[bi][b*L+k+4];
                        obs_w[got*L+k]         = sw_wj[idx][32*(L-k)-1 -: 32];
                    end
                    elst = exp_lst[bi] && (b == nbo - 1);
                    checks++;
                    if (sw_wj[idx] !== ewj) begin
                        failures++;
                        $display("FAIL wj cfg=%0d blk=%0d beat=%0d got %h want %h", idx, bi, b, sw_wj[idx], ewj);
                    end
                    checks++;
                    if (sw_wjj[idx] !== ewjj) begin
                        failures++;
                        $display("FAIL wjj cfg=%0d blk=%0d beat=%0d got %h want %h", idx, bi, b, sw_wjj[idx], ewjj);
                    end
                    checks++;
                    if (sw_lo[idx] !== elst) begin
                        failures++;
                        $display("FAIL lst_o cfg=%0d blk=%0d beat=%0d got %b want %b", idx, bi, b, sw_lo[idx], elst);
                    end
                    got++;
                end else begin
                    held = 1;
                    hwj  = sw_wj[idx];
                    hwjj = sw_wjj[idx];
                end
            end else if (started && chk_gap) begin
                gaps++;
            end
        end
        @(negedge clk);
        sw_ena[idx] = 1'b0;
        checks++;
        if (sw_vo[idx] !== 1'b0) begin
            failures++;
            $display("FAIL extra_beat cfg=%0d vld=%b after %0d beats want vld=0", idx, sw_vo[idx], got);
        end
        if (chk_gap) begin
            checks++;
            if (gaps != 0) begin
                failures++;
                $display("FAIL vld_gap cfg=%0d gaps=%0d want 0", idx, gaps);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NCFG; i++) begin
            checks++;
            if (sw_vo[i] !== 1'b0 || sw_lo[i] !== 1'b0 || sw_wj[i] !== '0 || sw_wjj[i] !== '0 || sw_rdy[i] !== 1'b1) begin
                failures++;
                $display("FAIL reset_state cfg=%0d vld=%b lst=%b rdy=%b wj=%h want vld=0 lst=0 rdy=1 wj=0",
                         i, sw_vo[i], sw_lo[i], sw_rdy[i], sw_wj[i]);
            end
        end
    endtask

    task automatic test_zero_block();
        for (int j = 0; j < 16; j++) msg[0][j] = '0;
        gen_model(0);
        exp_lst[0] = 1'b1;
        send_block(0, 0, 1'b1);
        checks++;
        if (sw_vo[0] !== 1'b0) begin
            failures++;
            $display("FAIL latency_t1 vld=%b want 0", sw_vo[0]);
        end
        @(negedge clk);
        checks++;
        if (sw_vo[0] !== 1'b1) begin
            failures++;
            $display("FAIL latency_t2 vld=%b want 1", sw_vo[0]);
        end
        collect(0, 1, 100, 0);
    endtask

    task automatic test_single_one();
        for (int j = 0; j < 16; j++) msg[0][j] = '0;
        msg[0][0] = 32'h0000_0001;
        gen_model(0);
        exp_lst[0] = 1'b1;
        send_block(0, 0, 1'b1);
        @(negedge clk);
        checks++;
        if (sw_wj[0][63:32] !== 32'h0000_0001 || sw_wjj[0][63:32] !== 32'h0000_0001) begin
            failures++;
            $display("FAIL beat0_lane0 wj=%h wjj=%h want 00000001/00000001", sw_wj[0][63:32], sw_wjj[0][63:32]);
        end
        collect(0, 1, 100, 0);
        checks++;
        if (obs_w[16] !== 32'h0080_8001) begin
            failures++;
            $display("FAIL w16 got %h want 00808001", obs_w[16]);
        end
    endtask

    task automatic test_back_to_back();
        fill_msg(0, 3);
        fill_msg(1, 29);
        gen_model(0);
        gen_model(1);
        exp_lst[0] = 1'b0;
        exp_lst[1] = 1'b1;
        fork
            begin
                send_block(0, 0, 1'b0);
                send_block(0, 1, 1'b1);
                @(negedge clk);
                checks++;
                if (sw_rdy[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL rdy_full rdy=%b want 0 while block 2 waits", sw_rdy[0]);
                end
            end
            collect(0, 2, 100, 1);
        join
    endtask

    task automatic test_backpressure();
        fill_msg(0, 5);
        gen_model(0);
        exp_lst[0] = 1'b1;
        fork
            send_block(0, 0, 1'b1);
            collect(0, 1, 30, 0);
        join
    endtask

    task automatic test_sweep();
        for (int i = 1; i < NCFG; i++) begin
            fill_msg(0, 40 + i);
            gen_model(0);
            exp_lst[0] = (i <= 4);
            send_block(i, 0, exp_lst[0]);
            checks++;
            if (sw_vo[i] !== (cfg_db(i) == 0)) begin
                failures++;
                $display("FAIL sweep_latency cfg=%0d vld=%b want %b", i, sw_vo[i], cfg_db(i) == 0);
            end
            collect(i, 1, 100, 0);
        end
    endtask

    task automatic test_reset_mid();
        int got   = 0;
        int guard = 0;
        fill_msg(0, 7);
        gen_model(0);
        exp_lst[0] = 1'b1;
        send_block(0, 0, 1'b1);
        while (got < 10 && guard < 200) begin
            @(negedge clk);
            guard++;
            sw_ena[0] = 1'b1;
            if (sw_vo[0] === 1'b1) got++;
        end
        @(negedge clk);
        sw_ena[0] = 1'b0;
        checks++;
        if (got != 10 || sw_wj[0][63:32] !== exp_w[0][20]) begin
            failures++;
            $display("FAIL pre_reset_beat10 transfers=%0d wj=%h want 10 and %h", got, sw_wj[0][63:32], exp_w[0][20]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sw_vo[0] !== 1'b0 || sw_lo[0] !== 1'b0 || sw_wj[0] !== '0 || sw_wjj[0] !== '0) begin
            failures++;
            $display("FAIL async_reset vld=%b lst=%b wj=%h wjj=%h want all 0", sw_vo[0], sw_lo[0], sw_wj[0], sw_wjj[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (sw_rdy[0] !== 1'b1 || sw_vo[0] !== 1'b0) begin
            failures++;
            $display("FAIL post_reset rdy=%b vld=%b want rdy=1 vld=0", sw_rdy[0], sw_vo[0]);
        end
        fill_msg(0, 11);
        gen_model(0);
        send_block(0, 0, 1'b1);
        collect(0, 1, 100, 0);
    endtask

    initial begin
        for (int i = 0; i < NCFG; i++) begin
            sw_d[i]   = '0;
            sw_vld[i] = 1'b0;
            sw_lst[i] = 1'b0;
            sw_ena[i] = 1'b0;
        end
        test_reset();
        test_zero_block();
        test_single_one();
        test_back_to_back();
        test_backpressure();
        test_sweep();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
